// File: rtl/booth_mul_arbiter_pkg.sv
// Shared types and defaults for the round-robin Booth multiplier front end.
package booth_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 16;
  localparam int DEF_TMO  = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE,
    S_DRAIN
  } state_t;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Handshake bus between the arbiter (master) and the shared multiplier (slave).
interface booth_mul_arbiter_if
  import booth_pkg::*;
#(
  parameter int W = DEF_W
);

  logic                       mul_rst;
  logic [W-1:0]               mul_a;
  logic [W-1:0]               mul_b;
  logic                       mul_busy;
  logic                       mul_read;
  logic [prod_width(W)-1:0]   mul_op;

  modport master (
    output mul_rst, mul_a, mul_b,
    input  mul_busy, mul_read, mul_op
  );

  modport slave (
    input  mul_rst, mul_a, mul_b,
    output mul_busy, mul_read, mul_op
  );

endinterface

// File: rtl/booth_mul_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping around.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  always_comb begin
    int i;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    i     = 0;
    for (int k = 0; k < NREQ; k++) begin
      i = (int'(ptr) + k) % NREQ;
      if (!valid && req[i]) begin
        valid    = 1'b1;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one multi-cycle multiplier among NREQ requesters with round-robin
// arbitration, a per-phase watchdog and a drain handshake before the next issue.
module booth_mul_arbiter
  import booth_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W,
  parameter int TMO  = DEF_TMO
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*W-1:0]        a_in,
  input  logic [NREQ*W-1:0]        b_in,
  output logic [NREQ-1:0]          done,
  output logic                     err,
  output logic [prod_width(W)-1:0] result,
  booth_mul_arbiter_if.master      mul
);

  localparam int            IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int            TW    = $clog2(TMO) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TMO - 1);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gid;
  logic [NREQ-1:0] gid_oh;
  logic [TW-1:0]   timer;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_valid;
  logic            expired;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign expired = (timer == TLAST);

  // A read that coincides with expiry wins, so the success branch is tested first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      gid         <= '0;
      gid_oh      <= '0;
      timer       <= '0;
      done        <= '0;
      err         <= 1'b0;
      result      <= '0;
      mul.mul_rst <= 1'b0;
      mul.mul_a   <= '0;
      mul.mul_b   <= '0;
    end else begin
      done   <= '0;
      err    <= 1'b0;
      result <= '0;
      unique case (state)
        S_IDLE: begin
          if (arb_valid) begin
            mul.mul_a   <= a_in[int'(arb_idx)*W +: W];
            mul.mul_b   <= b_in[int'(arb_idx)*W +: W];
            gid         <= arb_idx;
            gid_oh      <= arb_grant;
            timer       <= '0;
            mul.mul_rst <= 1'b1;
            state       <= S_START;
          end else begin
            mul.mul_rst <= 1'b0;
          end
        end
        S_START: begin
          if (mul.mul_read) begin
            result      <= mul.mul_op;
            done        <= gid_oh;
            mul.mul_rst <= 1'b0;
            state       <= S_DONE;
          end else if (mul.mul_busy) begin
            timer       <= '0;
            mul.mul_rst <= 1'b1;
            state       <= S_RUN;
          end else if (expired) begin
            err         <= 1'b1;
            done        <= gid_oh;
            mul.mul_rst <= 1'b0;
            state       <= S_DONE;
          end else begin
            timer       <= timer + 1'b1;
            mul.mul_rst <= 1'b1;
          end
        end
        S_RUN: begin
          if (mul.mul_read) begin
            result      <= mul.mul_op;
            done        <= gid_oh;
            mul.mul_rst <= 1'b0;
            state       <= S_DONE;
          end else if (expired) begin
            err         <= 1'b1;
            done        <= gid_oh;
            mul.mul_rst <= 1'b0;
            state       <= S_DONE;
          end else begin
            timer       <= timer + 1'b1;
            mul.mul_rst <= 1'b1;
          end
        end
        S_DONE: begin
          mul.mul_rst <= 1'b0;
          ptr         <= (gid == IW'(NREQ - 1)) ? '0 : gid + 1'b1;
          state       <= S_DRAIN;
        end
        S_DRAIN: begin
          mul.mul_rst <= 1'b0;
          if (!mul.mul_read && !mul.mul_busy) begin
            state <= S_IDLE;
          end
        end
        default: begin
          mul.mul_rst <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed-plus-random bench: behavioural multiplier on the bus, round-robin and
// signed-product reference model, assertion at every comparison point.
module tb_booth_mul_arbiter;
  import booth_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int TMO  = 64;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_STUCK  = 1;
  localparam int MODE_EARLY  = 2;

  logic              clk  = 1'b0;
  logic              rst  = 1'b0;
  logic [NREQ-1:0]   req  = '0;
  logic [NREQ*W-1:0] a_in = '0;
  logic [NREQ*W-1:0] b_in = '0;
  logic [NREQ-1:0]   done;
  logic              err;
  logic [2*W-1:0]    result;

  booth_mul_arbiter_if #(.W(W)) mul_if ();

  logic           m_busy = 1'b0;
  logic           m_read = 1'b0;
  logic [2*W-1:0] m_op   = '0;

  assign mul_if.mul_busy = m_busy;
  assign mul_if.mul_read = m_read;
  assign mul_if.mul_op   = m_op;

  int errors       = 0;
  int checks       = 0;
  int cyc          = 0;
  int run_entry    = 0;
  int done_cyc     = 0;
  int unstable_cnt = 0;
  int mode         = MODE_NORMAL;
  int lat          = 2;
  int ptr_m        = 0;
  int run_cnt      = 0;
  int drain_cnt    = 0;

  logic [W-1:0]   a_op       [NREQ];
  logic [W-1:0]   b_op       [NREQ];
  logic [2*W-1:0] res_by_idx [NREQ];
  logic           was_run = 1'b0;
  logic [W-1:0]   held_a  = '0;
  logic [W-1:0]   held_b  = '0;

  booth_mul_arbiter #(
    .NREQ (NREQ),
    .W    (W),
    .TMO  (TMO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .a_in   (a_in),
    .b_in   (b_in),
    .done   (done),
    .err    (err),
    .result (result),
    .mul    (mul_if.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [2*W-1:0] product(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[2*W-1:0];
  endfunction

  function automatic int next_rr(input logic [NREQ-1:0] pend, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (pend[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Multiplier stand-in: busy two cycles after start, read lat cycles later, drains in two.
  always @(negedge clk) begin
    if (!mul_if.mul_rst) begin
      run_cnt = 0;
      if (m_busy || m_read) begin
        drain_cnt++;
        if (drain_cnt >= 2) begin
          m_busy    = 1'b0;
          m_read    = 1'b0;
          m_op      = '0;
          drain_cnt = 0;
        end
      end
    end else begin
      drain_cnt = 0;
      run_cnt++;
      if (mode == MODE_EARLY) begin
        if (run_cnt == 1) begin
          m_read = 1'b1;
          m_op   = product(mul_if.mul_a, mul_if.mul_b);
        end
      end else begin
        if (run_cnt == 2) begin
          m_busy    = 1'b1;
          run_entry = cyc + 1;
        end
        if (mode == MODE_NORMAL && run_cnt == 3 + lat) begin
          m_read = 1'b1;
          m_op   = product(mul_if.mul_a, mul_if.mul_b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mul_if.mul_rst) begin
      if (was_run && (mul_if.mul_a !== held_a || mul_if.mul_b !== held_b)) unstable_cnt++;
      held_a  = mul_if.mul_a;
      held_b  = mul_if.mul_b;
      was_run = 1'b1;
    end else begin
      was_run = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r);
    req = r;
    for (int i = 0; i < NREQ; i++) begin
      a_in[i*W +: W] = a_op[i];
      b_in[i*W +: W] = b_op[i];
    end
  endtask

  task automatic waitDone(output int idx, output logic e, output logic [2*W-1:0] r);
    int   n;
    logic got;
    idx = -1;
    e   = 1'b0;
    r   = '0;
    got = 1'b0;
    n   = 0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      if (done != '0) begin
        got      = 1'b1;
        e        = err;
        r        = result;
        done_cyc = cyc;
        for (int i = NREQ - 1; i >= 0; i--) if (done[i]) idx = i;
        checkOutput("done_onehot", 64'($onehot(done)), 64'd1);
        checkOutput("mul_a_held", 64'(mul_if.mul_a), 64'(a_op[idx]));
        checkOutput("mul_b_held", 64'(mul_if.mul_b), 64'(b_op[idx]));
        checkOutput("operands_stable", 64'(unstable_cnt), 64'd0);
      end
    end
    checkOutput("done_seen", 64'(got), 64'd1);
  endtask

  task automatic serve(input int count, input logic [NREQ-1:0] hold, input logic exp_err);
    int             exp_idx;
    int             idx;
    logic           e;
    logic [2*W-1:0] r;
    for (int k = 0; k < count; k++) begin
      exp_idx = next_rr(req, ptr_m);
      waitDone(idx, e, r);
      checkOutput("grant_order", 64'(idx), 64'(exp_idx));
      checkOutput("err_flag", 64'(e), 64'(exp_err));
      if (exp_idx >= 0) begin
        checkOutput("result", 64'(r), exp_err ? 64'd0 : 64'(product(a_op[exp_idx], b_op[exp_idx])));
        res_by_idx[exp_idx] = r;
        ptr_m = (exp_idx + 1) % NREQ;
        if (!hold[exp_idx]) applyStimulus(req & ~(NREQ'(1) << exp_idx));
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int             idx;
    int             n;
    int             seen;
    logic           e;
    logic [2*W-1:0] r;
    logic [NREQ-1:0] mask;

    for (int i = 0; i < NREQ; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
      res_by_idx[i] = '0;
    end
    repeat (3) @(negedge clk);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_result", 64'(result), 64'd0);
    checkOutput("rst_mul_rst", 64'(mul_if.mul_rst), 64'd0);
    checkOutput("rst_mul_a", 64'(mul_if.mul_a), 64'd0);
    checkOutput("rst_mul_b", 64'(mul_if.mul_b), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] four simultaneous requests");
    a_op[0] = 16'h5689; b_op[0] = 16'h2dcb;
    a_op[1] = 16'h4253; b_op[1] = 16'hf234;
    a_op[2] = 16'hba79; b_op[2] = 16'ha763;
    a_op[3] = 16'hdbb9; b_op[3] = 16'hffe8;
    applyStimulus(4'b1111);
    serve(4, 4'b0000, 1'b0);
    checkOutput("slot3_value", 64'(res_by_idx[3]), 64'd222888);

    $display("[TB] single request on slot 0");
    a_op[0] = 16'h4828; b_op[0] = 16'h2929;
    applyStimulus(4'b0001);
    serve(1, 4'b0000, 1'b0);
    checkOutput("slot0_value", 64'(res_by_idx[0]), 64'd194639464);

    $display("[TB] slot 0 held with slot 2 pending");
    a_op[0] = 16'h0123; b_op[0] = 16'hfedc;
    a_op[2] = 16'h8000; b_op[2] = 16'h7fff;
    applyStimulus(4'b0101);
    serve(4, 4'b0101, 1'b0);
    applyStimulus(4'b0000);

    $display("[TB] stuck multiplier timeout");
    mode = MODE_STUCK;
    a_op[1] = 16'h1111; b_op[1] = 16'h2222;
    applyStimulus(4'b0010);
    serve(1, 4'b0000, 1'b1);
    checkOutput("tmo_latency", 64'(done_cyc - run_entry), 64'(TMO));
    mode = MODE_NORMAL;
    a_op[1] = 16'hffff; b_op[1] = 16'h8000;
    applyStimulus(4'b0010);
    serve(1, 4'b0000, 1'b0);

    $display("[TB] read asserted during start");
    mode = MODE_EARLY;
    a_op[3] = 16'h7fff; b_op[3] = 16'h7fff;
    applyStimulus(4'b1000);
    serve(1, 4'b0000, 1'b0);
    mode = MODE_NORMAL;

    $display("[TB] request dropped after grant");
    a_op[1] = 16'h0abc; b_op[1] = 16'hf00d;
    applyStimulus(4'b0010);
    n = 0;
    while (!mul_if.mul_rst && n < 20) begin
      @(negedge clk);
      n++;
    end
    applyStimulus(4'b0000);
    waitDone(idx, e, r);
    checkOutput("dropped_idx", 64'(idx), 64'd1);
    checkOutput("dropped_result", 64'(r), 64'(product(16'h0abc, 16'hf00d)));
    ptr_m = 2;

    $display("[TB] reset during run");
    mode = MODE_STUCK;
    a_op[2] = 16'h3039; b_op[2] = 16'hd431;
    applyStimulus(4'b0100);
    n = 0;
    while (!m_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput("running_before_rst", 64'(mul_if.mul_rst), 64'd1);
    rst = 1'b0;
    #1;
    checkOutput("arst_done", 64'(done), 64'd0);
    checkOutput("arst_err", 64'(err), 64'd0);
    checkOutput("arst_result", 64'(result), 64'd0);
    checkOutput("arst_mul_rst", 64'(mul_if.mul_rst), 64'd0);
    checkOutput("arst_mul_a", 64'(mul_if.mul_a), 64'd0);
    checkOutput("arst_mul_b", 64'(mul_if.mul_b), 64'd0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done != '0) seen++;
    end
    checkOutput("no_done_in_reset", 64'(seen), 64'd0);
    mode  = MODE_NORMAL;
    rst   = 1'b1;
    ptr_m = 0;
    serve(1, 4'b0000, 1'b0);

    $display("[TB] random rounds");
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        a_op[i] = W'($urandom);
        b_op[i] = W'($urandom);
      end
      lat  = int'($urandom_range(0, 4));
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      applyStimulus(mask);
      serve($countones(mask), 4'b0000, 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
